// File: rtl/dma_bus_arb_pkg.sv
// Shared types, AHB constants and the round-robin search used by the DMA bus arbiter.
package dma_bus_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam int unsigned RR_MAX_CH    = 8;

  // Returns {found, index}: first set bit of req at or after ptr, wrapping modulo n.
  function automatic logic [3:0] rr_pick(input logic [RR_MAX_CH-1:0] req,
                                         input logic [2:0] ptr,
                                         input int unsigned n);
    logic [3:0]  res;
    int unsigned idx;
    res = '0;
    for (int unsigned off = 0; off < RR_MAX_CH; off++) begin
      idx = (32'(ptr) + off) % n;
      if ((off < n) && !res[3] && req[idx[2:0]]) res = {1'b1, idx[2:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester at or after the pointer.
module rr_picker
  import dma_bus_arb_pkg::*;
#(
  parameter  int unsigned N  = 2,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  onehot_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  logic [RR_MAX_CH-1:0] req_ext;
  logic [3:0]           pick;
  logic [IW-1:0]        idx;

  always_comb begin
    req_ext           = '0;
    req_ext[N-1:0]    = req_i;
    pick              = rr_pick(req_ext, 3'(ptr_i), N);
    idx               = IW'(pick[2:0]);
    onehot_o          = '0;
    if (pick[3]) onehot_o[idx] = 1'b1;
    idx_o             = idx;
    valid_o           = pick[3];
  end

endmodule

// File: rtl/dma_bus_arbiter.sv
// Round-robin, beat-quota arbiter sharing one AHB master port among DMA channels.
// Optional sticky per-channel error capture enabled by DMA_BUS_ARB_ERR_EN.
module dma_bus_arbiter
  import dma_bus_arb_pkg::*;
#(
  parameter  int unsigned ADDR_WIDTH = 32,
  parameter  int unsigned DATA_WIDTH = 32,
  parameter  int unsigned CHANNEL    = 2,
  parameter  int unsigned MAX_BEATS  = 4,
  localparam int unsigned IDW        = $clog2(CHANNEL),
  localparam int unsigned CW         = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [CHANNEL-1:0]              ch_req,
  input  logic [CHANNEL*ADDR_WIDTH-1:0]   ch_haddr,
  input  logic [CHANNEL-1:0]              ch_hwrite,
  input  logic [CHANNEL*DATA_WIDTH-1:0]   ch_hwdata,
  output logic [CHANNEL-1:0]              ch_gnt,
  output logic [CHANNEL-1:0]              ch_hready,
  output logic [DATA_WIDTH-1:0]           ch_hrdata,
  output logic [ADDR_WIDTH-1:0]           m_haddr,
  output logic [DATA_WIDTH-1:0]           m_hwdata,
  output logic                            m_hwrite,
  output logic [2:0]                      m_hsize,
  output logic [2:0]                      m_hburst,
  input  logic [DATA_WIDTH-1:0]           m_hrdata,
  input  logic                            m_hready,
  input  logic [1:0]                      m_hresp,
  output logic                            busy,
  output logic [IDW-1:0]                  owner_id,
  output logic [CHANNEL-1:0]              err_flags,
  input  logic [CHANNEL-1:0]              err_clr
);

  arb_state_e         state_q, state_d;
  logic [CHANNEL-1:0] gnt_q, gnt_d;
  logic [IDW-1:0]     owner_q, owner_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]      beat_cnt_q, beat_cnt_d;

  logic [CHANNEL-1:0] pick_onehot;
  logic [IDW-1:0]     pick_idx;
  logic               pick_valid;
  logic               beat_done, quota_hit, other_req, resp_err, release_bus;
  logic [IDW-1:0]     next_ptr;

  rr_picker #(.N(CHANNEL)) u_rr_picker (
    .req_i    (ch_req),
    .ptr_i    (rr_ptr_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .valid_o  (pick_valid)
  );

  assign beat_done   = (state_q == OWN) & m_hready;
  assign quota_hit   = (beat_cnt_q == CW'(MAX_BEATS - 1));
  assign other_req   = |(ch_req & ~gnt_q);
  assign next_ptr    = (owner_q == IDW'(CHANNEL - 1)) ? '0 : owner_q + 1'b1;
  assign release_bus = !ch_req[owner_q] || (beat_done && quota_hit && other_req) || resp_err;

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d    = OWN;
          gnt_d      = pick_onehot;
          owner_d    = pick_idx;
          beat_cnt_d = '0;
        end
      end
      OWN: begin
        if (release_bus) begin
          state_d    = IDLE;
          gnt_d      = '0;
          owner_d    = '0;
          rr_ptr_d   = next_ptr;
          beat_cnt_d = '0;
        end else if (beat_done && !quota_hit) begin
          // Saturates at the quota while nobody else is waiting.
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

`ifdef DMA_BUS_ARB_ERR_EN
  logic [CHANNEL-1:0] err_q, err_d;

  assign resp_err = beat_done && (m_hresp != 2'b00);

  always_comb begin
    err_d = err_q & ~err_clr;
    if (resp_err) err_d[owner_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) err_q <= '0;
    else        err_q <= err_d;
  end

  assign err_flags = err_q;
`else
  logic unused_err;
  assign resp_err   = 1'b0;
  assign err_flags  = '0;
  assign unused_err = ^{m_hresp, err_clr};
`endif

  always_comb begin
    m_haddr  = '0;
    m_hwdata = '0;
    m_hwrite = 1'b0;
    if (state_q == OWN) begin
      m_haddr  = ch_haddr[owner_q*ADDR_WIDTH +: ADDR_WIDTH];
      m_hwdata = ch_hwdata[owner_q*DATA_WIDTH +: DATA_WIDTH];
      m_hwrite = ch_hwrite[owner_q];
    end
  end

  assign ch_gnt    = gnt_q;
  assign ch_hready = gnt_q & {CHANNEL{m_hready}};
  assign ch_hrdata = m_hrdata;
  assign m_hsize   = HSIZE_WORD;
  assign m_hburst  = HBURST_SINGLE;
  assign busy      = (state_q == OWN);
  assign owner_id  = owner_q;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Directed plus random bench for dma_bus_arbiter against a transaction-level reference model.
module tb_dma_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CH = 2;
  localparam int MB = 4;
  localparam int IW = $clog2(CH);

  logic              clk = 1'b0;
  logic              rst_n;
  logic [CH-1:0]     ch_req;
  logic [CH*AW-1:0]  ch_haddr;
  logic [CH-1:0]     ch_hwrite;
  logic [CH*DW-1:0]  ch_hwdata;
  logic [CH-1:0]     ch_gnt;
  logic [CH-1:0]     ch_hready;
  logic [DW-1:0]     ch_hrdata;
  logic [AW-1:0]     m_haddr;
  logic [DW-1:0]     m_hwdata;
  logic              m_hwrite;
  logic [2:0]        m_hsize;
  logic [2:0]        m_hburst;
  logic [DW-1:0]     m_hrdata;
  logic              m_hready;
  logic [1:0]        m_hresp;
  logic              busy;
  logic [IW-1:0]     owner_id;
  logic [CH-1:0]     err_flags;
  logic [CH-1:0]     err_clr;

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the bus (-1 = nobody), beats served this tenure, rotation start.
  int            mdl_owner = -1;
  int            mdl_beats = 0;
  int            mdl_ptr   = 0;
  logic [CH-1:0] mdl_err   = '0;

  dma_bus_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .CHANNEL    (CH),
    .MAX_BEATS  (MB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ch_req    (ch_req),
    .ch_haddr  (ch_haddr),
    .ch_hwrite (ch_hwrite),
    .ch_hwdata (ch_hwdata),
    .ch_gnt    (ch_gnt),
    .ch_hready (ch_hready),
    .ch_hrdata (ch_hrdata),
    .m_haddr   (m_haddr),
    .m_hwdata  (m_hwdata),
    .m_hwrite  (m_hwrite),
    .m_hsize   (m_hsize),
    .m_hburst  (m_hburst),
    .m_hrdata  (m_hrdata),
    .m_hready  (m_hready),
    .m_hresp   (m_hresp),
    .busy      (busy),
    .owner_id  (owner_id),
    .err_flags (err_flags),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    int  prev_owner;
    bit  done, errb, other, found;
    prev_owner = mdl_owner;
    errb       = 1'b0;
    if (!rst_n) begin
      mdl_owner = -1;
      mdl_beats = 0;
      mdl_ptr   = 0;
      mdl_err   = '0;
      return;
    end
    if (mdl_owner < 0) begin
      found = 1'b0;
      for (int k = 0; k < CH; k++) begin
        int c;
        c = (mdl_ptr + k) % CH;
        if (!found && ch_req[c]) begin
          found     = 1'b1;
          mdl_owner = c;
          mdl_beats = 0;
        end
      end
    end else begin
      done = m_hready;
`ifdef DMA_BUS_ARB_ERR_EN
      errb = done && (m_hresp != 2'b00);
`endif
      other = 1'b0;
      for (int k = 0; k < CH; k++)
        if (k != mdl_owner && ch_req[k]) other = 1'b1;
      if (!ch_req[mdl_owner] || (done && (mdl_beats + 1 >= MB) && other) || errb) begin
        mdl_ptr   = (mdl_owner + 1) % CH;
        mdl_owner = -1;
      end else if (done) begin
        mdl_beats++;
      end
    end
`ifdef DMA_BUS_ARB_ERR_EN
    mdl_err = mdl_err & ~err_clr;
    if (errb) mdl_err[prev_owner] = 1'b1;
`endif
  endtask

  task automatic check_all();
    logic [CH-1:0] eg;
    eg = '0;
    if (mdl_owner >= 0) eg[mdl_owner] = 1'b1;
    chk("gnt", 64'(ch_gnt), 64'(eg));
    chk("busy", 64'(busy), 64'(mdl_owner >= 0));
    chk("owner_id", 64'(owner_id), (mdl_owner >= 0) ? 64'(mdl_owner) : 64'd0);
    chk("m_haddr", 64'(m_haddr), (mdl_owner >= 0) ? 64'(ch_haddr[mdl_owner*AW +: AW]) : 64'd0);
    chk("m_hwdata", 64'(m_hwdata), (mdl_owner >= 0) ? 64'(ch_hwdata[mdl_owner*DW +: DW]) : 64'd0);
    chk("m_hwrite", 64'(m_hwrite), (mdl_owner >= 0) ? 64'(ch_hwrite[mdl_owner]) : 64'd0);
    chk("ch_hready", 64'(ch_hready), 64'(eg & {CH{m_hready}}));
    chk("ch_hrdata", 64'(ch_hrdata), 64'(m_hrdata));
    chk("err_flags", 64'(err_flags), 64'(mdl_err));
    chk("m_hsize", 64'(m_hsize), 64'd2);
    chk("m_hburst", 64'(m_hburst), 64'd0);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    rst_n     = 1'b0;
    ch_req    = '0;
    ch_haddr  = {32'h1000_0004, 32'h0000_1000};
    ch_hwrite = 2'b01;
    ch_hwdata = {32'h1111_2222, 32'h3333_4444};
    m_hrdata  = 32'hCAFE_0001;
    m_hready  = 1'b1;
    m_hresp   = 2'b00;
    err_clr   = '0;
    #2;
    tick();
    tick();
    chk("reset_gnt", 64'(ch_gnt), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_haddr", 64'(m_haddr), 64'd0);

    // ch0 alone keeps the bus for 10 beats with no contention.
    rst_n  = 1'b1;
    ch_req = 2'b01;
    tick();
    chk("solo_first_gnt", 64'(ch_gnt), 64'd1);
    for (int i = 0; i < 10; i++) tick();
    chk("solo_held_gnt", 64'(ch_gnt), 64'd1);
    ch_req = 2'b00;
    tick();
    chk("solo_release", 64'(ch_gnt), 64'd0);
    tick();

    // Both request: 4 beats each with one bubble between owners.
    ch_req = 2'b11;
    for (int i = 0; i < 22; i++) tick();
    ch_req = 2'b00;
    tick();
    tick();

    // ch1 ownership mux and bubble.
    ch_haddr[AW +: AW]  = 32'h2000_0010;
    ch_hwdata[DW +: DW] = 32'hA5A5_0001;
    ch_hwrite           = 2'b10;
    ch_req              = 2'b10;
    tick();
    chk("ch1_gnt", 64'(ch_gnt), 64'd2);
    chk("ch1_haddr", 64'(m_haddr), 64'h2000_0010);
    chk("ch1_hwdata", 64'(m_hwdata), 64'hA5A5_0001);
    chk("ch1_hwrite", 64'(m_hwrite), 64'd1);
    ch_req = 2'b00;
    tick();
    chk("bubble_haddr", 64'(m_haddr), 64'd0);

    // Wait states freeze the quota count and hold the grant.
    ch_req = 2'b01;
    tick();
    tick();
    ch_req   = 2'b11;
    m_hready = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("stall_gnt", 64'(ch_gnt), 64'd1);
    chk("stall_hready", 64'(ch_hready), 64'd0);
    m_hready = 1'b1;
    tick();
    tick();
    chk("stall_still_owner", 64'(ch_gnt), 64'd1);
    tick();
    chk("stall_quota_release", 64'(ch_gnt), 64'd0);

    // Reset while ch1 owns.
    tick();
    chk("ch1_owns", 64'(ch_gnt), 64'd2);
    rst_n = 1'b0;
    tick();
    chk("rst_mid_gnt", 64'(ch_gnt), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    rst_n  = 1'b1;
    ch_req = 2'b10;
    tick();
    chk("post_rst_gnt1", 64'(ch_gnt), 64'd2);

    // Pointer returns to 0 on reset even after ch0 rotated it to 1.
    ch_req = 2'b00;
    tick();
    ch_req = 2'b01;
    tick();
    ch_req = 2'b00;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n  = 1'b1;
    ch_req = 2'b11;
    tick();
    chk("rst_ptr_zero", 64'(ch_gnt), 64'd1);
    ch_req = 2'b00;
    tick();
    tick();

`ifdef DMA_BUS_ARB_ERR_EN
    ch_req = 2'b01;
    tick();
    tick();
    m_hresp = 2'b01;
    tick();
    chk("err_set", 64'(err_flags), 64'd1);
    chk("err_release", 64'(ch_gnt), 64'd0);
    m_hresp = 2'b00;
    ch_req  = 2'b00;
    err_clr = 2'b01;
    tick();
    chk("err_clear", 64'(err_flags), 64'd0);
    err_clr = 2'b00;
    tick();
`endif

    for (int i = 0; i < 400; i++) begin
      ch_req    = CH'($urandom) | CH'($urandom);
      m_hready  = ($urandom_range(0, 3) != 0);
      m_hresp   = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      err_clr   = ($urandom_range(0, 7) == 0) ? CH'($urandom) : '0;
      rst_n     = ($urandom_range(0, 99) != 0);
      ch_haddr  = {$urandom, $urandom};
      ch_hwdata = {$urandom, $urandom};
      ch_hwrite = CH'($urandom);
      m_hrdata  = $urandom;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
